// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the SPI slave and the application SPI master.
package spi_pkg;

  localparam int         SPI_BITS      = 8;
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage resettable synchroniser; each bit has its own reset value.
module spi_sync #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [STAGES-1:0] sync_reg;

      // Shift the asynchronous pin through STAGES flops.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_reg <= {STAGES{RST_VAL[gi]}};
        else       sync_reg <= {sync_reg[STAGES-2:0], d_i[gi]};
      end

      assign q_o[gi] = sync_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 target bridging an oversampled SPI bus to a byte valid/ready stream.
// Optional macro SPI_SLAVE_ERR_FLAGS_EN adds sticky overrun_o / underrun_o flags.
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = SPI_FILL_BYTE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  output logic       in_ready_o,
  output logic       overrun_o,
  output logic       underrun_o
`else
  output logic       in_ready_o
`endif
);

  localparam int CNT_W = $clog2(SPI_BITS);

  logic [2:0] pin_sync;
  logic       sck_s, csn_s, mosi_s;
  logic       sck_prev_reg, csn_prev_reg;
  logic       sck_rise, sck_fall, csn_fall, csn_rise;

  spi_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [SPI_BITS-1:0] tx_sr_reg, tx_sr_next;
  logic [SPI_BITS-1:0] rx_sr_reg, rx_sr_next;
  logic [SPI_BITS-1:0] out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic                oe_reg, oe_next;
  logic                load, byte_done, overrun_evt;

  // Pin order {mosi, csn, sck}; idle bus is csn high, sck and mosi low.
  spi_sync #(
    .STAGES  (SYNC_STAGES),
    .WIDTH   (3),
    .RST_VAL (3'b010)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({mosi_i, csn_i, sck_i}),
    .q_o   (pin_sync)
  );

  assign sck_s  = pin_sync[0];
  assign csn_s  = pin_sync[1];
  assign mosi_s = pin_sync[2];

  // Previous synchronised sample, for edge decoding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_prev_reg <= 1'b0;
      csn_prev_reg <= 1'b1;
    end else begin
      sck_prev_reg <= sck_s;
      csn_prev_reg <= csn_s;
    end
  end

  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign csn_fall = ~csn_s & csn_prev_reg;
  assign csn_rise = csn_s & ~csn_prev_reg;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= SPI_IDLE;
      bit_cnt_reg   <= '0;
      tx_sr_reg     <= '0;
      rx_sr_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      oe_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      tx_sr_reg     <= tx_sr_next;
      rx_sr_reg     <= rx_sr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      oe_reg        <= oe_next;
    end
  end

  // Next-state logic: loads on select and at byte boundaries, shifting on sck edges.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    tx_sr_next     = tx_sr_reg;
    rx_sr_next     = rx_sr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    oe_next        = oe_reg;
    load           = 1'b0;
    byte_done      = 1'b0;
    overrun_evt    = 1'b0;

    case (state_reg)
      SPI_IDLE: begin
        // sck edges coinciding with select are ignored.
        if (csn_fall) begin
          state_next   = SPI_ACTIVE;
          load         = 1'b1;
          bit_cnt_next = '0;
          oe_next      = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (sck_rise) begin
          rx_sr_next   = {rx_sr_reg[SPI_BITS-2:0], mosi_s};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          byte_done    = (bit_cnt_reg == CNT_W'(SPI_BITS - 1));
        end else if (sck_fall && !csn_rise) begin
          if (bit_cnt_reg != '0) tx_sr_next = {tx_sr_reg[SPI_BITS-2:0], 1'b0};
          else                   load       = 1'b1;
        end
        // A byte finishing together with deselect is still delivered below.
        if (csn_rise) begin
          state_next   = SPI_IDLE;
          bit_cnt_next = '0;
          oe_next      = 1'b0;
        end
      end
      default: state_next = SPI_IDLE;
    endcase

    if (load) tx_sr_next = in_valid_i ? in_data_i : FILL_BYTE;

    if (out_valid_reg && out_ready_i) out_valid_next = 1'b0;
    if (byte_done) begin
      if (!out_valid_reg || out_ready_i) begin
        out_data_next  = {rx_sr_reg[SPI_BITS-2:0], mosi_s};
        out_valid_next = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end
  end

  assign in_ready_o  = load;
  assign miso_o      = oe_reg & tx_sr_reg[SPI_BITS-1];
  assign miso_oe_o   = oe_reg;
  assign out_data_o  = out_data_reg;
  assign out_valid_o = out_valid_reg;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic overrun_reg, underrun_reg;
  logic flag_clr;

  assign flag_clr = (state_reg == SPI_IDLE) && csn_fall;

  // Sticky error flags; a fill load on the selecting edge sets underrun again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      overrun_reg  <= (flag_clr ? 1'b0 : overrun_reg) | overrun_evt;
      underrun_reg <= (flag_clr ? 1'b0 : underrun_reg) | (load & ~in_valid_i);
    end
  end

  assign overrun_o  = overrun_reg;
  assign underrun_o = underrun_reg;
`else
  logic unused_overrun;
  assign unused_overrun = overrun_evt;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed cases plus randomized transactions.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int H    = 12;  // sck half period in clk cycles (48 MHz / 2 MHz)

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       sck_i = 1'b0, csn_i = 1'b1, mosi_i = 1'b0;
  logic       miso_o, miso_oe_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic [7:0] in_data_i = 8'h00;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic       overrun_o, underrun_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] in_q[$];
  logic [7:0] got_q[$];
  logic [7:0] mosi_bytes[$];
  logic [7:0] miso_got[$];
  int         xfer_cnt = 0;
  int         hook_bit = -1;
  logic [7:0] hook_exp = 8'h00;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sck_i       (sck_i),
    .csn_i       (csn_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    .in_ready_o  (in_ready_o),
    .overrun_o   (overrun_o),
    .underrun_o  (underrun_o)
`else
    .in_ready_o  (in_ready_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // IN source: presents the head of in_q; pops after an observed handshake edge.
  initial begin
    bit pop_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
      in_valid_i = (in_q.size() > 0);
      in_data_i  = (in_q.size() > 0) ? in_q[0] : 8'h00;
      #2;
      pop_pend = in_ready_o && in_valid_i;
      if (pop_pend) xfer_cnt++;
    end
  end

  // OUT sink: records every byte accepted at the following clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid_o && out_ready_i) got_q.push_back(out_data_o);
    end
  end

  // Mode 0 master: MOSI changes on sck fall, MISO sampled at sck rise.
  task automatic spi_xfer(input int nbytes, input int cut_bits);
    int nbits;
    logic [7:0] rx;
    nbits = (cut_bits > 0) ? cut_bits : nbytes * 8;
    rx = 8'h00;
    @(negedge clk);
    csn_i  = 1'b0;
    mosi_i = mosi_bytes[0][7];
    wait_clk(H);
    for (int b = 0; b < nbits; b++) begin
      rx = {rx[6:0], miso_o};
      if (b % 8 == 7) miso_got.push_back(rx);
      sck_i = 1'b1;
      if (b == hook_bit) begin
        wait_clk(SYNC);
        out_ready_i = 1'b1;
        wait_clk(1);
        out_ready_i = 1'b0;
        check("hook_valid", out_valid_o, 1'b1);
        check("hook_data", out_data_o, hook_exp);
        wait_clk(H - SYNC - 1);
      end else begin
        wait_clk(H);
      end
      sck_i = 1'b0;
      if (b + 1 < nbits) mosi_i = mosi_bytes[(b + 1) / 8][7 - ((b + 1) % 8)];
      wait_clk(H);
    end
    csn_i  = 1'b1;
    mosi_i = 1'b0;
    wait_clk(SYNC);
    check("oe_before_deselect", miso_oe_o, 1'b1);
    wait_clk(1);
    check("oe_after_deselect", miso_oe_o, 1'b0);
    check("miso_after_deselect", miso_o, 1'b0);
    wait_clk(2 * H);
  endtask

  task automatic clear_logs();
    got_q.delete();
    miso_got.delete();
    mosi_bytes.delete();
    xfer_cnt = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_miso"}, miso_o, 1'b0);
    check({tag, "_oe"}, miso_oe_o, 1'b0);
    check({tag, "_valid"}, out_valid_o, 1'b0);
    check({tag, "_data"}, out_data_o, 8'h00);
    check({tag, "_inrdy"}, in_ready_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b1, b2;
    int nb, qn, exp_xfer, exp_left;
    logic [7:0] exp_miso[$];

    wait_clk(3);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    wait_clk(4);

    // Single byte: A5 in, 3C out, one accepted IN transfer.
    clear_logs();
    in_q.push_back(8'h3C);
    mosi_bytes.push_back(8'hA5);
    spi_xfer(1, 0);
    check("single_cnt", got_q.size(), 1);
    check("single_out", got_q[0], 8'hA5);
    check("single_miso", miso_got[0], 8'h3C);
    check("single_xfers", xfer_cnt, 1);

    // Three bytes, no IN data: fill bytes returned.
    clear_logs();
    in_q.delete();
    mosi_bytes = '{8'h01, 8'h02, 8'h03};
    spi_xfer(3, 0);
    check("b2b_cnt", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_out%0d", i), got_q[i], i + 1);
      check($sformatf("b2b_miso%0d", i), miso_got[i], 8'hFF);
    end
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("b2b_underrun", underrun_o, 1'b1);
    check("b2b_overrun", overrun_o, 1'b0);
`endif

    // Sink stalled for two bytes: second byte dropped.
    clear_logs();
    out_ready_i = 1'b0;
    mosi_bytes = '{8'h11, 8'h22};
    spi_xfer(2, 0);
    check("ovr_valid", out_valid_o, 1'b1);
    check("ovr_data", out_data_o, 8'h11);
    check("ovr_cnt_stalled", got_q.size(), 0);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("ovr_flag", overrun_o, 1'b1);
`endif
    out_ready_i = 1'b1;
    wait_clk(3);
    check("ovr_cnt", got_q.size(), 1);
    check("ovr_out", got_q[0], 8'h11);
    check("ovr_valid_drained", out_valid_o, 1'b0);

    // Deselect after 5 bits: nothing delivered, next byte clean.
    clear_logs();
    mosi_bytes = '{8'hF0};
    spi_xfer(1, 5);
    check("cut_cnt", got_q.size(), 0);
    check("cut_valid", out_valid_o, 1'b0);
    clear_logs();
    mosi_bytes = '{8'h5A};
    spi_xfer(1, 0);
    check("after_cut_cnt", got_q.size(), 1);
    check("after_cut_out", got_q[0], 8'h5A);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check("after_cut_overrun_clr", overrun_o, 1'b0);
`endif

    // Same-cycle accept: ready pulsed exactly on the edge byte 2 completes.
    clear_logs();
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    mosi_bytes = '{b1, b2};
    hook_exp = b2;
    hook_bit = 15;
    out_ready_i = 1'b0;
    spi_xfer(2, 0);
    hook_bit = -1;
    check("same_cyc_cnt", got_q.size(), 1);
    check("same_cyc_b1", got_q[0], b1);
    out_ready_i = 1'b1;
    wait_clk(3);
    check("same_cyc_cnt2", got_q.size(), 2);
    check("same_cyc_b2", got_q[1], b2);

    // Randomized transactions against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      clear_logs();
      exp_miso.delete();
      in_q.delete();
      nb = $urandom_range(1, 4);
      qn = $urandom_range(0, nb + 2);
      for (int i = 0; i < nb; i++) mosi_bytes.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < qn; i++) in_q.push_back(8'($urandom_range(0, 255)));
      // Load k supplies byte k; one more load happens at the final boundary.
      for (int i = 0; i < nb; i++) exp_miso.push_back(i < qn ? in_q[i] : 8'hFF);
      exp_xfer = (qn < nb + 1) ? qn : nb + 1;
      exp_left = qn - exp_xfer;
      spi_xfer(nb, 0);
      check($sformatf("rnd%0d_cnt", t), got_q.size(), nb);
      for (int i = 0; i < nb; i++) begin
        check($sformatf("rnd%0d_out%0d", t, i), got_q[i], mosi_bytes[i]);
        check($sformatf("rnd%0d_miso%0d", t, i), miso_got[i], exp_miso[i]);
      end
      check($sformatf("rnd%0d_xfers", t), xfer_cnt, exp_xfer);
      check($sformatf("rnd%0d_left", t), in_q.size(), exp_left);
    end

    // Reset mid-byte, then sck activity without a new select.
    clear_logs();
    in_q.delete();
    out_ready_i = 1'b0;
    @(negedge clk);
    csn_i = 1'b0;
    mosi_i = 1'b1;
    wait_clk(H);
    for (int i = 0; i < 8; i++) begin
      sck_i = 1'b1; wait_clk(H);
      sck_i = 1'b0; wait_clk(H);
    end
    for (int i = 0; i < 3; i++) begin
      sck_i = 1'b1; wait_clk(H);
      sck_i = 1'b0; wait_clk(H);
    end
    check("pre_rst_valid", out_valid_o, 1'b1);
    #1;
    rst_i = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    csn_i = 1'b1;
    wait_clk(4);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 16; i++) begin
      mosi_i = 1'($urandom_range(0, 1));
      sck_i = 1'b1; wait_clk(H);
      sck_i = 1'b0; wait_clk(H);
    end
    check("post_rst_cnt", got_q.size(), 0);
    check_idle_outputs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
